// File: rtl/vec_accum_stream.sv
// Streaming per-lane frame reducer: sums, maxima or sums of squares over FRAME
// input beats, with results queued in a small output FIFO.
module vec_accum_stream #(
   parameter int LANES  = 8,
   parameter int DW     = 8,
   parameter int OW     = 32,
   parameter int FRAME  = 4,
   parameter int ODEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  din_vld,
   output logic                  din_busy,
   input  logic [LANES*DW-1:0]   din_data,
   input  logic [1:0]            cfg_mode,
   output logic                  dout_vld,
   input  logic                  dout_busy,
   output logic [LANES*OW-1:0]   dout_data
);

   localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam int PW = (ODEPTH > 1) ? $clog2(ODEPTH) : 1;
   localparam int NW = $clog2(ODEPTH + 1);

   localparam logic [CW-1:0] C_LAST = CW'(FRAME - 1);
   localparam logic [PW-1:0] P_LAST = PW'(ODEPTH - 1);
   localparam logic [NW-1:0] N_FULL = NW'(ODEPTH);

   logic [CW-1:0]          r_cnt;
   logic [1:0]             r_mode;
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [NW-1:0]          r_count;
   logic [LANES*OW-1:0]    r_mem [ODEPTH];

   logic                   w_full;
   logic                   w_empty;
   logic                   w_first;
   logic                   w_last;
   logic                   w_accept;
   logic                   w_push;
   logic                   w_pop;
   logic [1:0]             w_mode;
   logic [LANES*OW-1:0]    w_result;

   assign w_full   = (r_count == N_FULL);
   assign w_empty  = (r_count == '0);
   assign w_first  = (r_cnt == '0);
   assign w_last   = (r_cnt == C_LAST);
   assign w_pop    = ~w_empty & ~dout_busy;

   // Only a frame-completing beat can overflow the FIFO; earlier beats always go in.
   assign din_busy = rst | (w_full & w_last & dout_busy);
   assign w_accept = din_vld & ~din_busy;
   assign w_push   = w_accept & w_last;

   // The first beat of a frame uses the live mode; later beats use the latched copy.
   assign w_mode   = w_first ? cfg_mode : r_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_mode <= '0;
      end else if (w_accept) begin
         r_cnt <= w_last ? '0 : r_cnt + CW'(1);
         if (w_first) begin
            r_mode <= cfg_mode;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [OW-1:0] r_acc;
         logic [OW-1:0] w_x;
         logic [OW-1:0] w_sq;
         logic [OW-1:0] w_res;

         assign w_x  = OW'(din_data[gi*DW +: DW]);
         assign w_sq = w_x * w_x;

         always_comb begin
            case (w_mode)
               2'd1:    w_res = (w_x > r_acc) ? w_x : r_acc;
               2'd2:    w_res = r_acc + w_sq;
               default: w_res = r_acc + w_x;
            endcase
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_acc <= '0;
            end else if (w_accept) begin
               r_acc <= w_last ? '0 : w_res;
            end
         end

         assign w_result[gi*OW +: OW] = w_res;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + NW'(1);
            2'b01:   r_count <= r_count - NW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_result;
      end
   end

   // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
   assign dout_vld  = ~w_empty;
   assign dout_data = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_vec_accum_stream.sv
// Bench for vec_accum_stream: directed table, corner sequences and random
// traffic against a frame-level reference model.
module tb_vec_accum_stream;

   localparam int LANES  = 8;
   localparam int DW     = 8;
   localparam int OW     = 32;
   localparam int FRAME  = 4;
   localparam int ODEPTH = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 din_vld;
   logic                 din_busy;
   logic [LANES*DW-1:0]  din_data;
   logic [1:0]           cfg_mode;
   logic                 dout_vld;
   logic                 dout_busy;
   logic [LANES*OW-1:0]  dout_data;

   logic                 din2_vld;
   logic                 din2_busy;
   logic [63:0]          din2_data;
   logic [1:0]           cfg2_mode;
   logic                 dout2_vld;
   logic                 dout2_busy;
   logic [127:0]         dout2_data;

   vec_accum_stream #(.LANES(LANES), .DW(DW), .OW(OW), .FRAME(FRAME), .ODEPTH(ODEPTH)) u_dut (
      .clk(clk), .rst(rst), .din_vld(din_vld), .din_busy(din_busy), .din_data(din_data),
      .cfg_mode(cfg_mode), .dout_vld(dout_vld), .dout_busy(dout_busy), .dout_data(dout_data)
   );

   vec_accum_stream #(.LANES(8), .DW(8), .OW(16), .FRAME(2), .ODEPTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .din_vld(din2_vld), .din_busy(din2_busy), .din_data(din2_data),
      .cfg_mode(cfg2_mode), .dout_vld(dout2_vld), .dout_busy(dout2_busy), .dout_data(dout2_data)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int outs  = 0;
   int stalls = 0;

   // Reference model state: completed results in order, plus the beats of the open frame.
   logic [255:0] mq [$];
   int           m_cnt;
   logic [1:0]   m_mode;
   logic [63:0]  m_beats [FRAME];

   typedef struct {
      logic [1:0]      mode;
      logic [3:0][7:0] v;
      logic [31:0]     exp;
   } vec_t;

   vec_t tbl [7];

   task automatic chkb(input string name, input bit act, input bit exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0b, want %0b", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] frame_result(input logic [1:0] mode);
      logic [255:0] r;
      longint acc;
      longint x;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         acc = 0;
         for (int k = 0; k < FRAME; k++) begin
            x = longint'(m_beats[k][l*DW +: DW]);
            if (mode == 2'd1)      acc = (x > acc) ? x : acc;
            else if (mode == 2'd2) acc = acc + x * x;
            else                   acc = acc + x;
         end
         r[l*OW +: OW] = acc[OW-1:0];
      end
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_cnt  = 0;
      m_mode = 2'd0;
   endtask

   // One clock cycle: check outputs against the model, advance the model, cross the edge.
   task automatic tick(output bit acc);
      bit m_busy;
      bit m_pop;
      logic [255:0] h;
      #2;
      m_busy = (mq.size() == ODEPTH) && (m_cnt == FRAME - 1) && dout_busy;
      chkb("din_busy", din_busy, m_busy);
      chkb("dout_vld", dout_vld, mq.size() != 0);
      if (mq.size() != 0) chkw("dout_data", dout_data, mq[0]);
      m_pop = (mq.size() != 0) && !dout_busy;
      acc   = din_vld && !m_busy;
      if (m_pop) begin
         h = mq.pop_front();
         $display("[TB] out %0d lane0=%0d lane7=%0d", outs, h[31:0], h[255:224]);
         outs++;
      end
      if (acc) begin
         m_beats[m_cnt] = din_data;
         if (m_cnt == 0) m_mode = cfg_mode;
         if (m_cnt == FRAME - 1) begin
            mq.push_back(frame_result(m_mode));
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [63:0] d, input logic [1:0] m);
      bit a;
      int n;
      din_vld  = 1'b1;
      din_data = d;
      cfg_mode = m;
      n = 0;
      a = 1'b0;
      while (!a && n < 50) begin
         tick(a);
         n++;
      end
      if (n > 1) stalls += n - 1;
      if (!a) begin
         tests++;
         fails++;
         $display("[TB] FAIL beat_timeout: got no acceptance, want acceptance within 50 cycles");
      end
      din_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      bit a;
      din_vld = 1'b0;
      repeat (n) tick(a);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a;
      tbl[0] = '{mode: 2'd0, v: {8'd255, 8'd255, 8'd255, 8'd255}, exp: 32'd1020};
      tbl[1] = '{mode: 2'd1, v: {8'd199, 8'd7,   8'd200, 8'd3},   exp: 32'd200};
      tbl[2] = '{mode: 2'd2, v: {8'd255, 8'd255, 8'd255, 8'd255}, exp: 32'd260100};
      tbl[3] = '{mode: 2'd3, v: {8'd4,   8'd3,   8'd2,   8'd1},   exp: 32'd10};
      tbl[4] = '{mode: 2'd0, v: {8'd0,   8'd0,   8'd0,   8'd0},   exp: 32'd0};
      tbl[5] = '{mode: 2'd2, v: {8'd4,   8'd3,   8'd2,   8'd1},   exp: 32'd30};
      tbl[6] = '{mode: 2'd1, v: {8'd0,   8'd0,   8'd0,   8'd0},   exp: 32'd0};

      rst = 1'b1; din_vld = 1'b0; din_data = '0; cfg_mode = 2'd0; dout_busy = 1'b0;
      din2_vld = 1'b0; din2_data = '0; cfg2_mode = 2'd0; dout2_busy = 1'b0;
      model_reset();
      #3;
      chkb("rst_din_busy", din_busy, 1'b1);
      chkb("rst_dout_vld", dout_vld, 1'b0);
      chkw("rst_dout_data", dout_data, 256'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Single-frame table with dout_busy low
      for (int t = 0; t < 7; t++) begin
         for (int k = 0; k < FRAME; k++) beat({8{tbl[t].v[k]}}, tbl[t].mode);
         chkb("tbl_vld", dout_vld, 1'b1);
         chkw("tbl_data", dout_data, {8{tbl[t].exp}});
         idle(1);
         chkb("tbl_vld_one_cycle", dout_vld, 1'b0);
      end

      // Mode change mid-frame is ignored until the next frame
      beat({8{8'd5}}, 2'd1); beat({8{8'd9}}, 2'd1); beat({8{8'd2}}, 2'd0); beat({8{8'd1}}, 2'd0);
      chkw("modechg_max", dout_data, {8{32'd9}});
      beat({8{8'd5}}, 2'd0); beat({8{8'd9}}, 2'd0); beat({8{8'd2}}, 2'd1); beat({8{8'd1}}, 2'd1);
      chkw("modechg_sum", dout_data, {8{32'd17}});
      idle(2);

      // Backpressure: three back-to-back frames into a 2-deep FIFO
      dout_busy = 1'b1;
      stalls = 0;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < FRAME; k++) begin
            if (f == 2 && k == FRAME - 1) begin
               chkw("bp_no_early_stall", 256'(stalls), 256'd0);
               din_vld  = 1'b1;
               din_data = {8{8'(f * 16 + k)}};
               cfg_mode = 2'd0;
               chkb("bp_stall", din_busy, 1'b1);
               tick(a);
               tick(a);
               chkb("bp_stall_hold", din_busy, 1'b1);
               dout_busy = 1'b0;
               tick(a);
               chkb("bp_accept_on_pop", a, 1'b1);
               din_vld = 1'b0;
            end else begin
               beat({8{8'(f * 16 + k)}}, 2'd0);
            end
         end
      end
      idle(4);
      chkw("bp_drained", 256'(outs), 256'd12);

      // Reset with a queued result and a partial frame
      dout_busy = 1'b1;
      for (int k = 0; k < FRAME; k++) beat({8{8'd10}}, 2'd0);
      beat({8{8'd50}}, 2'd0);
      beat({8{8'd60}}, 2'd0);
      rst = 1'b1;
      #1;
      chkb("midrst_dout_vld", dout_vld, 1'b0);
      chkb("midrst_din_busy", din_busy, 1'b1);
      chkw("midrst_dout_data", dout_data, 256'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      dout_busy = 1'b0;
      for (int k = 0; k < FRAME; k++) beat({8{8'd1}}, 2'd0);
      chkw("midrst_fresh_frame", dout_data, {8{32'd4}});
      idle(2);

      // Wrap-around on a 16-bit output, FRAME=2 instance
      din2_vld  = 1'b1;
      din2_data = {8{8'hFF}};
      cfg2_mode = 2'd2;
      tick(a);
      tick(a);
      din2_vld = 1'b0;
      chkb("wrap_vld", dout2_vld, 1'b1);
      chkw("wrap_data", 256'(dout2_data), 256'({8{16'd64514}}));
      tick(a);
      chkb("wrap_vld_clear", dout2_vld, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         din_vld   = ($urandom_range(0, 9) < 7);
         din_data  = {$urandom, $urandom};
         cfg_mode  = 2'($urandom_range(0, 3));
         dout_busy = ($urandom_range(0, 9) < 4);
         tick(a);
      end
      dout_busy = 1'b0;
      idle(4);
      chkb("rand_drained", dout_vld, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
